// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
package if_id_pkg;

  // Widest program counter an entry can carry; if_id_reg uses the low PC_W bits.
  localparam int unsigned PC_MAX_W = 64;

  localparam logic [31:0] IF_ID_NOP = 32'h0000_0000;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  typedef struct packed {
    logic                valid;
    logic [PC_MAX_W-1:0] pc;
    logic [31:0]         instr;
  } entry_t;

  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/if_id_fields.sv
// Combinational field split of the decode-side instruction word.
module if_id_fields
  import if_id_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [15:0] imm16_o,
  output logic        zext_o
);

  assign rs_o    = instr_i[25:21];
  assign rt_o    = instr_i[20:16];
  assign rd_o    = instr_i[15:11];
  assign imm16_o = instr_i[15:0];
  assign zext_o  = is_zext_op(instr_i[31:26]);

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer and redirect flush.
// Define IF_ID_STATS_EN to add the stall_cnt/flush_cnt counters.
module if_id_reg
  import if_id_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = IF_ID_NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [15:0]     out_imm16,
  output logic            out_zext
`ifdef IF_ID_STATS_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_ent, empty_ent;
  logic   accept;
  logic   main_free;

  assign in_ready  = !skid_q.valid && !reset;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_q.valid || out_ready;

  always_comb begin
    in_ent                = '0;
    in_ent.valid          = 1'b1;
    in_ent.pc[PC_W-1:0]   = in_pc;
    in_ent.instr          = in_instr;
    empty_ent             = '0;
    empty_ent.instr       = NOP_INSTR;
    main_d                = main_q;
    skid_d                = skid_q;
    if (main_free) begin
      // Skid is older than any input, so it always wins the slot in main.
      if (skid_q.valid) begin
        main_d = skid_q;
        skid_d = accept ? in_ent : empty_ent;
      end else if (accept) begin
        main_d = in_ent;
      end else begin
        main_d = empty_ent;
      end
    end else if (accept) begin
      skid_d = in_ent;
    end
    if (flush) begin
      main_d = empty_ent;
      skid_d = empty_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= empty_ent;
      skid_q <= empty_ent;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_valid = main_q.valid;
  assign out_pc    = main_q.valid ? main_q.pc[PC_W-1:0] : '0;
  assign out_instr = main_q.valid ? main_q.instr : NOP_INSTR;

  if (PC_W < PC_MAX_W) begin : g_pc_pad
    logic unused_pc_hi;
    assign unused_pc_hi = ^main_q.pc[PC_MAX_W-1:PC_W];
  end

  if_id_fields u_fields (
    .instr_i (out_instr),
    .rs_o    (out_rs),
    .rt_o    (out_rt),
    .rd_o    (out_rd),
    .imm16_o (out_imm16),
    .zext_o  (out_zext)
  );

`ifdef IF_ID_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_q.valid && !out_ready && (stall_q != '1)) stall_q <= stall_q + 16'd1;
      if (flush && (flush_q != '1)) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: doc/if_id_reg.md
IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter width.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word driven when no entry is valid.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid  input  1, in_ready  output  1, in_pc  input  PC_W, in_instr  input  32: fetch-side handshake and payload.
REQ-006 SHALL have port flush  input  1  discard all held entries (branch/jump redirect).
REQ-007 SHALL have ports out_valid  output  1, out_ready  input  1, out_pc  output  PC_W, out_instr  output  32: decode-side handshake and payload.
REQ-008 SHALL have ports out_rs, out_rt, out_rd  output  5 each, and out_imm16  output  16: fields of out_instr that feed the sign-extend stage.
REQ-009 SHALL have port out_zext  output  1  high selects zero-extension of out_imm16, low selects sign-extension.

Function
REQ-010 SHALL hold two entries: main (drives outputs) and skid; each has a valid bit, pc and instr.
REQ-011 SHALL drive in_ready = !skid_valid && !reset.
REQ-012 SHALL accept the input on a cycle when in_valid && in_ready.
REQ-013 SHALL treat main as free when !main_valid || out_ready.
  - If main is free and skid is valid, skid moves to main.
  - Otherwise the accepted input moves to main.
REQ-014 SHALL write an accepted input into skid when main is not free, or when skid is moving to main on the same cycle.
REQ-015 SHALL clear main_valid when main is free and no source is available.
REQ-016 SHALL make the handshake latency exactly 1 cycle: an input accepted at edge N is visible on out_* after edge N when main was free.
REQ-017 SHALL preserve order: entries leave in the order they were accepted; no entry is dropped or duplicated.
REQ-018 SHALL, when flush is high, clear main_valid and skid_valid at the next edge and ignore any same-cycle input; flush SHALL take priority over all transfers.
REQ-019 SHALL drive out_instr = NOP_INSTR and out_pc = 0 whenever main_valid is 0.
REQ-020 SHALL drive the decoded fields combinationally from out_instr:
  - rs = [25:21], rt = [20:16], rd = [15:11], imm16 = [15:0].
REQ-021 SHALL set out_zext = 1 for opcode out_instr[31:26] in {6'h0C ANDI, 6'h0D ORI, 6'h0E XORI, 6'h0F LUI}, else 0.

Reset
REQ-022 SHALL, while reset is high at an edge, clear both valid bits, pc registers to 0 and instr registers to NOP_INSTR; reset takes priority over flush and all transfers.
REQ-023 SHALL, after reset, give: out_valid = 0, out_instr = NOP_INSTR, out_pc = 0, out_zext = 0, in_ready = 1 (0 while reset is high), counters = 0.

Configuration
REQ-024 SHALL compile, with IF_ID_STATS_EN defined, two outputs:
  - stall_cnt[15:0]: increments on each cycle with out_valid && !out_ready.
  - flush_cnt[15:0]: increments on each cycle with flush high.
  - Both saturate at 16'hFFFF and clear on reset.
REQ-025 SHALL, without IF_ID_STATS_EN, have neither port nor the counter logic.

Structure
REQ-026 SHALL place the following in shared package if_id_pkg:
  - opcode constants (OP_ANDI, OP_ORI, OP_XORI, OP_LUI);
  - the NOP constant;
  - a packed entry typedef {valid, pc, instr}.
REQ-027 SHALL implement field extraction and out_zext in one combinational sub-module if_id_fields, instantiated once.

Verification
REQ-028 SHALL cover single pass:
  - Stimulus: reset 2 cycles, then in_instr=32'h2008_FFFF (ADDI), pc=0x40, out_ready=1.
  - Required: out_valid next cycle, out_imm16=16'hFFFF, out_zext=0, out_rt=8.
REQ-029 SHALL cover backpressure:
  - Stimulus: out_ready=0 while three instrs are offered.
  - Required: first in main, second in skid, in_ready=0 on third.
  - Then out_ready=1: outputs appear in order, one per cycle.
REQ-030 SHALL cover flush with both entries full:
  - Stimulus: flush=1 and in_valid=1 on the same cycle.
  - Required: next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1, the same-cycle input is dropped.
REQ-031 SHALL cover the zero-extend decode:
  - Stimulus: ORI 32'h3509_8000.
  - Required: out_zext=1, out_imm16=16'h8000.
REQ-032 SHALL cover reset mid-operation:
  - Stimulus: reset asserted with skid full.
  - Required: next cycle all valid bits 0 and no stale entry later emerges.
REQ-033 SHALL cover stats, with IF_ID_STATS_EN:
  - Stimulus: 5 stalled cycles, then 2 flush cycles.
  - Required: stall_cnt=5, flush_cnt=2.
